// File: rtl/store_commit_buffer_if.sv
// Cache store-port request bundle: index/data request phase, then the tag phase
// one cycle after grant. The buffer is the master, the cache is the slave.
interface store_commit_buffer_if #(
    parameter int INDEX_WIDTH = 12,
    parameter int TAG_WIDTH   = 44
);
    logic                   req_o;
    logic [INDEX_WIDTH-1:0] index_o;
    logic                   we_o;
    logic [63:0]            wdata_o;
    logic [7:0]             be_o;
    logic [1:0]             size_o;
    logic                   kill_o;
    logic                   gnt_i;
    logic                   tag_valid_o;
    logic [TAG_WIDTH-1:0]   tag_o;

    modport master (
        output req_o, index_o, we_o, wdata_o, be_o, size_o, kill_o,
        output tag_valid_o, tag_o,
        input  gnt_i
    );

    modport slave (
        input  req_o, index_o, we_o, wdata_o, be_o, size_o, kill_o,
        input  tag_valid_o, tag_o,
        output gnt_i
    );
endinterface

// File: rtl/store_commit_buffer.sv
// In-order commit store buffer feeding the data cache store port, with a
// page-offset alias check for younger loads and an empty flag for fences.
module store_commit_buffer #(
    parameter int DEPTH       = 8,
    parameter int INDEX_WIDTH = 12,
    parameter int TAG_WIDTH   = 44
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           valid_i,
    output logic                           ready_o,
    input  logic [TAG_WIDTH+INDEX_WIDTH-1:0] paddr_i,
    input  logic [63:0]                    data_i,
    input  logic [7:0]                     be_i,
    input  logic [1:0]                     size_i,
    store_commit_buffer_if.master          dc,
    input  logic [11:0]                    page_offset_i,
    output logic                           page_offset_match_o,
    output logic                           empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int AW = TAG_WIDTH + INDEX_WIDTH;

    typedef enum logic {S_REQ = 1'b0, S_TAG = 1'b1} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [PW:0]   r_count;

    logic [AW-1:0] r_paddr [DEPTH];
    logic [63:0]   r_data  [DEPTH];
    logic [7:0]    r_be    [DEPTH];
    logic [1:0]    r_size  [DEPTH];

    logic             w_push;
    logic             w_pop;
    logic             w_req;
    logic [DEPTH-1:0] w_hit;

    assign ready_o = (r_count != (PW+1)'(DEPTH));
    assign empty_o = (r_count == '0);
    assign w_push  = valid_i && ready_o;
    assign w_pop   = (r_state == S_TAG);
    assign w_req   = (r_state == S_REQ) && (r_count != '0);

    // Entry payload needs no reset: liveness is tracked by the pointers/count.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_paddr[r_wr_ptr] <= paddr_i;
            r_data[r_wr_ptr]  <= data_i;
            r_be[r_wr_ptr]    <= be_i;
            r_size[r_wr_ptr]  <= size_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_REQ;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_REQ:   if (w_req && dc.gnt_i) w_state_next = S_TAG;
            S_TAG:   w_state_next = S_REQ;
            default: w_state_next = S_REQ;
        endcase
    end

    // Request fields stay on the head entry in both states, so they are
    // stable while the cache withholds its grant.
    assign dc.req_o       = w_req;
    assign dc.we_o        = w_req;
    assign dc.kill_o      = 1'b0;
    assign dc.index_o     = r_paddr[r_rd_ptr][INDEX_WIDTH-1:0];
    assign dc.wdata_o     = r_data[r_rd_ptr];
    assign dc.be_o        = r_be[r_rd_ptr];
    assign dc.size_o      = r_size[r_rd_ptr];
    assign dc.tag_valid_o = (r_state == S_TAG);
    assign dc.tag_o       = r_paddr[r_rd_ptr][AW-1:INDEX_WIDTH];

    // An entry is live when its distance from the head is below the count;
    // the in-flight head stays live until its tag cycle completes.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_alias
            logic [PW-1:0] w_dist;
            logic          w_live;
            assign w_dist     = PW'(gi) - r_rd_ptr;
            assign w_live     = ({1'b0, w_dist} < r_count);
            assign w_hit[gi]  = w_live && (r_paddr[gi][11:3] == page_offset_i[11:3]);
        end
    endgenerate

    assign page_offset_match_o = |w_hit;

endmodule

// File: tb/tb_store_commit_buffer.sv
// Directed and randomized bench for store_commit_buffer against a queue model.
module tb_store_commit_buffer;
    localparam int DEPTH = 8;

    typedef struct {
        logic [55:0] paddr;
        logic [63:0] data;
        logic [7:0]  be;
        logic [1:0]  size;
    } st_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        ready;
    logic [55:0] paddr;
    logic [63:0] data;
    logic [7:0]  be;
    logic [1:0]  size;
    logic [11:0] po;
    logic        match;
    logic        empty;

    int total = 0;
    int bad   = 0;

    st_t q[$];
    bit  tag_ph;

    store_commit_buffer_if ifc ();

    store_commit_buffer #(.DEPTH(DEPTH), .INDEX_WIDTH(12), .TAG_WIDTH(44)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .valid_i             (valid),
        .ready_o             (ready),
        .paddr_i             (paddr),
        .data_i              (data),
        .be_i                (be),
        .size_i              (size),
        .dc                  (ifc),
        .page_offset_i       (po),
        .page_offset_match_o (match),
        .empty_o             (empty)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        int n;
        bit m;
        n = q.size();
        m = 0;
        foreach (q[k]) if (q[k].paddr[11:3] == po[11:3]) m = 1;
        chk("ready", ready, 64'(n != DEPTH));
        chk("req", ifc.req_o, 64'(!tag_ph && n != 0));
        chk("we", ifc.we_o, 64'(!tag_ph && n != 0));
        chk("kill", ifc.kill_o, 64'd0);
        chk("tag_valid", ifc.tag_valid_o, 64'(tag_ph));
        chk("empty", empty, 64'(n == 0));
        chk("match", match, 64'(m));
        if (n != 0) begin
            chk("index", ifc.index_o, 64'(q[0].paddr[11:0]));
            chk("wdata", ifc.wdata_o, q[0].data);
            chk("be", ifc.be_o, 64'(q[0].be));
            chk("size", ifc.size_o, 64'(q[0].size));
            if (tag_ph) chk("tag", ifc.tag_o, 64'(q[0].paddr[55:12]));
        end
    endtask

    // One clock: check outputs against the model, advance DUT and model.
    task automatic tick();
        bit  do_pop, do_gnt, do_push;
        st_t e;
        #1;
        check_model();
        do_pop  = tag_ph;
        do_gnt  = !tag_ph && q.size() != 0 && ifc.gnt_i;
        do_push = valid && q.size() != DEPTH;
        e.paddr = paddr; e.data = data; e.be = be; e.size = size;
        if (valid && q.size() == DEPTH) $display("note: upstream valid while full, store dropped");
        @(posedge clk);
        if (rst) begin
            q.delete();
            tag_ph = 0;
        end else begin
            if (do_pop) begin
                void'(q.pop_front());
                tag_ph = 0;
            end else if (do_gnt) begin
                tag_ph = 1;
            end
            if (do_push) q.push_back(e);
        end
        #1;
    endtask

    task automatic push(input logic [55:0] a, input logic [63:0] d);
        valid = 1; paddr = a; data = d; be = 8'($urandom); size = 2'($urandom);
        tick();
        valid = 0;
    endtask

    task automatic drain_expect(input int first, input int n);
        ifc.gnt_i = 1;
        for (int k = 0; k < n; k++) begin
            #1;
            chk("drain_req", ifc.req_o, 64'd1);
            chk("drain_data", ifc.wdata_o, 64'(first + k));
            tick();
            tick();
        end
        ifc.gnt_i = 0;
    endtask

    initial begin
        rst = 1; valid = 0; paddr = '0; data = '0; be = '0; size = '0; po = '0;
        ifc.gnt_i = 0;
        q.delete(); tag_ph = 0;
        @(posedge clk); #1;
        tick(); tick();
        rst = 0;

        // Reset state
        #1;
        chk("rst_ready", ready, 64'd1);
        chk("rst_empty", empty, 64'd1);
        chk("rst_req", ifc.req_o, 64'd0);
        chk("rst_tag_valid", ifc.tag_valid_o, 64'd0);
        chk("rst_match", match, 64'd0);
        chk("rst_kill", ifc.kill_o, 64'd0);
        tick();

        // Single store, grant tied high
        ifc.gnt_i = 1;
        valid = 1; paddr = 56'h0000_0012_3458; data = 64'hDEADBEEF_00000000; be = 8'hF0; size = 2'd2;
        tick();
        valid = 0;
        #1;
        chk("single_req", ifc.req_o, 64'd1);
        chk("single_index", ifc.index_o, 64'h458);
        chk("single_wdata", ifc.wdata_o, 64'hDEADBEEF_00000000);
        chk("single_be", ifc.be_o, 64'hF0);
        tick();
        #1;
        chk("single_tag_valid", ifc.tag_valid_o, 64'd1);
        chk("single_tag", ifc.tag_o, 64'h123);
        tick();
        #1;
        chk("single_empty", empty, 64'd1);
        ifc.gnt_i = 0;
        tick();

        // Grant stall for 5 cycles
        push({$urandom, $urandom}, 64'h1111_2222_3333_4444);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("stall_req", ifc.req_o, 64'd1);
            chk("stall_data", ifc.wdata_o, 64'h1111_2222_3333_4444);
            chk("stall_tag_valid", ifc.tag_valid_o, 64'd0);
            tick();
        end
        ifc.gnt_i = 1;
        tick();
        ifc.gnt_i = 0;
        #1;
        chk("stall_tag_valid_after", ifc.tag_valid_o, 64'd1);
        tick();

        // Fill to full, overflow attempt, drain, then wrap
        for (int d = 1; d <= 8; d++) push({$urandom, $urandom}, 64'(d));
        #1;
        chk("full_ready", ready, 64'd0);
        valid = 1; paddr = {$urandom, $urandom}; data = 64'd9;
        tick();
        valid = 0;
        drain_expect(1, 8);
        #1;
        chk("full_drained_empty", empty, 64'd1);
        for (int d = 10; d <= 12; d++) push({$urandom, $urandom}, 64'(d));
        drain_expect(10, 3);

        // Push during the tag cycle keeps the count and order
        for (int d = 21; d <= 23; d++) push({$urandom, $urandom}, 64'(d));
        ifc.gnt_i = 1;
        tick();
        ifc.gnt_i = 0;
        #1;
        chk("pp_tag_valid", ifc.tag_valid_o, 64'd1);
        push({$urandom, $urandom}, 64'd24);
        #1;
        chk("pp_ready", ready, 64'd1);
        chk("pp_empty", empty, 64'd0);
        drain_expect(22, 3);

        // Alias check
        push({44'($urandom), 12'h108}, 64'd31);
        push({44'($urandom), 12'h7F0}, 64'd32);
        po = 12'h10C; #1; chk("alias_10c", match, 64'd1);
        po = 12'h110; #1; chk("alias_110", match, 64'd0);
        po = 12'h7F7; #1; chk("alias_7f7", match, 64'd1);
        tick();
        drain_expect(31, 2);
        po = 12'h108; #1; chk("alias_after_pop", match, 64'd0);
        tick();

        // Reset in the grant cycle with four entries
        for (int d = 41; d <= 44; d++) push({$urandom, $urandom}, 64'(d));
        ifc.gnt_i = 1; rst = 1;
        tick();
        ifc.gnt_i = 0; rst = 0;
        #1;
        chk("midrst_tag_valid", ifc.tag_valid_o, 64'd0);
        chk("midrst_req", ifc.req_o, 64'd0);
        chk("midrst_empty", empty, 64'd1);
        chk("midrst_ready", ready, 64'd1);
        tick();

        // Randomized traffic against the model
        for (int c = 0; c < 800; c++) begin
            valid = 1'($urandom_range(0, 1));
            paddr = {$urandom, $urandom};
            data = {$urandom, $urandom};
            be = 8'($urandom);
            size = 2'($urandom);
            ifc.gnt_i = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 199) == 0);
            if (q.size() != 0 && $urandom_range(0, 1) == 1)
                po = q[$urandom_range(0, q.size() - 1)].paddr[11:0] ^ 12'($urandom_range(0, 7));
            else
                po = 12'($urandom);
            tick();
        end
        valid = 0; rst = 0; ifc.gnt_i = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
